// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of a fixed-latency ROM, one read in flight at a time.
// Optional build macro ROM_ARB_ADDR_CHECK_EN adds an address range check against ROM_DEPTH.
module rom_arbiter #(
  parameter int ROM_LAT   = 2,
  parameter int ROM_DEPTH = 138
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_addr,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_addr,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [7:0]  rom_addr,
  output logic        rom_cs,
  output logic        rom_oe,
  input  logic [15:0] rom_data
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0] CNT_INIT = 3'(ROM_LAT - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q;
  logic       port_q;
  logic       last_grant_q;
  logic       bad_q;
  logic       acc;
  logic       win;
  logic [7:0] acc_addr;
  logic       acc_bad;

  // Tie goes to the port that did not win last time.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == IDLE) begin
      req0_ready = req0_valid & (~req1_valid | last_grant_q);
      req1_ready = req1_valid & (~req0_valid | ~last_grant_q);
    end
  end

  assign acc      = req0_ready | req1_ready;
  assign win      = req1_ready;
  assign acc_addr = win ? req1_addr : req0_addr;

`ifdef ROM_ARB_ADDR_CHECK_EN
  localparam logic [8:0] DEPTH9 = 9'(ROM_DEPTH);
  assign acc_bad = ({1'b0, acc_addr} >= DEPTH9);
`else
  assign acc_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = WAIT;
      WAIT:    if (cnt_q == 3'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range reads spend a single dead cycle in WAIT with the ROM left idle.
  assign rom_cs = (state_q == WAIT) & ~bad_q;
  assign rom_oe = rom_cs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      port_q       <= 1'b0;
      last_grant_q <= 1'b1;
      bad_q        <= 1'b0;
      rom_addr     <= 8'h00;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp_data     <= 16'hFFFF;
      rsp_err      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp0_valid <= (state_q == RESP) & ~port_q;
      rsp1_valid <= (state_q == RESP) &  port_q;
      case (state_q)
        IDLE: if (acc) begin
          port_q       <= win;
          last_grant_q <= win;
          bad_q        <= acc_bad;
          cnt_q        <= acc_bad ? 3'd0 : CNT_INIT;
          if (!acc_bad) rom_addr <= acc_addr;
        end
        WAIT: begin
          if (cnt_q == 3'd0) begin
            rsp_data <= bad_q ? 16'hFFFF : rom_data;
            rsp_err  <= bad_q;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: vector table of arbitration cases plus hand sequences,
// with a reference model and response scoreboard checked on every falling edge.
module tb_rom_arbiter;
  localparam int LAT   = 2;
  localparam int DEPTH = 138;
`ifdef ROM_ARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_addr, req1_addr;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  rom_addr;
  logic        rom_cs, rom_oe;
  logic [15:0] rom_data;

  always #5 clk = ~clk;

  rom_arbiter #(.ROM_LAT(LAT), .ROM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_oe(rom_oe), .rom_data(rom_data)
  );

  function automatic logic [15:0] rom_fn(input logic [7:0] a);
    if (a == 8'h05) return 16'h007F;
    return {a ^ 8'h5A, ~a};
  endfunction

  assign rom_data = rom_fn(rom_addr);

  typedef struct {
    bit          port;
    logic [15:0] data;
    bit          err;
    int          due;
  } exp_t;

  typedef struct {
    bit         v0;
    logic [7:0] a0;
    bit         v1;
    logic [7:0] a1;
    bit         exp_port;
  } vec_t;

  exp_t sb[$];
  bit   glog[$];
  int   nchk = 0, nerr = 0;
  int   cyc = 0, free_at = 0, cs_lo = 0, cs_hi = -1, n_acc = 0;
  bit   m_last = 1'b1;
  logic [7:0] m_addr = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sb.delete();
        free_at = cyc;
        cs_lo   = 0;
        cs_hi   = -1;
        m_last  = 1'b1;
      end else begin
        bit e0, e1, bad, incs;
        int len;
        logic [7:0] a;
        exp_t e;
        e0 = 1'b0;
        e1 = 1'b0;
        if (cyc >= free_at) begin
          e0 = req0_valid & (!req1_valid | m_last);
          e1 = req1_valid & (!req0_valid | !m_last);
        end
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        incs = (cyc >= cs_lo) && (cyc <= cs_hi);
        chk("rom_cs", rom_cs, incs);
        chk("rom_oe", rom_oe, incs);
        if (incs) chk("rom_addr", rom_addr, m_addr);
        if (rsp0_valid | rsp1_valid) begin
          if (sb.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL unexpected_rsp: got rsp0=%0b rsp1=%0b expected none (cycle %0d)",
                     rsp0_valid, rsp1_valid, cyc);
          end else begin
            e = sb.pop_front();
            chk("rsp_cycle", cyc, e.due);
            chk("rsp0_valid", rsp0_valid, !e.port);
            chk("rsp1_valid", rsp1_valid, e.port);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", rsp_err, e.err);
          end
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
          nchk++; nerr++;
          $display("FAIL missing_rsp: got no pulse expected one at cycle %0d", sb[0].due);
          e = sb.pop_front();
        end
        if (e0 | e1) begin
          a   = e1 ? req1_addr : req0_addr;
          bad = CHK && (a >= DEPTH);
          len = bad ? 1 : LAT;
          m_last = e1;
          n_acc++;
          glog.push_back(req1_ready);
          if (!bad) begin
            m_addr = a;
            cs_lo  = cyc + 1;
            cs_hi  = cyc + LAT;
          end
          free_at = cyc + len + 2;
          e.port  = e1;
          e.data  = bad ? 16'hFFFF : rom_fn(a);
          e.err   = bad;
          e.due   = cyc + len + 2;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic wait_accept(input string nm, input int start, input int cnt, input int budget);
    int w;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (n_acc < start + cnt && w < budget);
    if (n_acc < start + cnt) chk({nm, "_timeout"}, n_acc - start, cnt);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_rsp0_valid"}, rsp0_valid, 1'b0);
    chk({nm, "_rsp1_valid"}, rsp1_valid, 1'b0);
    chk({nm, "_rsp_data"}, rsp_data, 16'hFFFF);
    chk({nm, "_rsp_err"}, rsp_err, 1'b0);
    chk({nm, "_rom_cs"}, rom_cs, 1'b0);
    chk({nm, "_rom_oe"}, rom_oe, 1'b0);
    chk({nm, "_rom_addr"}, rom_addr, 8'h00);
    chk({nm, "_req0_ready"}, req0_ready, 1'b0);
    chk({nm, "_req1_ready"}, req1_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int   start;
    tbl[0] = '{1'b1, 8'h05, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 8'h10, 1'b1, 8'h20, 1'b1};
    tbl[2] = '{1'b1, 8'h10, 1'b1, 8'h20, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 8'hC8, 1'b1};
    tbl[5] = '{1'b1, 8'h8A, 1'b1, 8'h89, 1'b0};
    tbl[6] = '{1'b1, 8'h00, 1'b1, 8'hFF, 1'b1};
    tbl[7] = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0};
    tbl[8] = '{1'b1, 8'h40, 1'b1, 8'h41, 1'b1};

    rst_n = 1'b0;
    idle_inputs();
    req0_addr = 8'h00;
    req1_addr = 8'h00;
    #12;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Arbitration table; each entry is held until accepted, then the bus idles.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      req0_valid = tbl[i].v0; req0_addr = tbl[i].a0;
      req1_valid = tbl[i].v1; req1_addr = tbl[i].a1;
      start = n_acc;
      wait_accept("tbl_accept", start, 1, 20);
      if (n_acc > start) chk("tbl_grant", glog[glog.size()-1], tbl[i].exp_port);
      idle_inputs();
      repeat (LAT + 4) @(posedge clk);
    end

    // Reset asserted while the ROM read is in flight.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 8'h42;
    start = n_acc;
    wait_accept("rst_accept", start, 1, 20);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midwait");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (LAT + 8) @(posedge clk);
    #1;
    chk("post_rst_rsp_data", rsp_data, 16'hFFFF);

    // Both ports requesting continuously must alternate, starting with port 0.
    glog.delete();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 8'h10;
    req1_valid = 1'b1; req1_addr = 8'h20;
    start = n_acc;
    wait_accept("rr_accept", start, 4, 60);
    idle_inputs();
    chk("rr_count", glog.size(), 4);
    for (int k = 0; k < 4 && k < glog.size(); k++)
      chk($sformatf("rr_grant%0d", k), glog[k], k % 2);
    repeat (LAT + 6) @(posedge clk);

    // Port 1 raises valid mid-read and withdraws it before ever being accepted.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 8'h07;
    start = n_acc;
    wait_accept("drop_accept", start, 1, 20);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 8'h30;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (LAT + 6) @(posedge clk);
    #1;
    chk("drop_accepts", n_acc - start, 1);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
